// File: rtl/booth_encode_pkg.sv
// Shared definitions for the radix-16 Booth digit encoder and the partial-product
// generator that consumes its output fields.
package booth_encode_pkg;

    localparam int WIN_W = 5;
    localparam int SEL_W = 4;

    // One-hot odd-multiple selects
    localparam logic [SEL_W-1:0] SEL_NONE = 4'b0000;
    localparam logic [SEL_W-1:0] SEL_1X   = 4'b0001;
    localparam logic [SEL_W-1:0] SEL_3X   = 4'b0010;
    localparam logic [SEL_W-1:0] SEL_5X   = 4'b0100;
    localparam logic [SEL_W-1:0] SEL_7X   = 4'b1000;

    // One-hot left-shift selects
    localparam logic [SEL_W-1:0] SHL_0 = 4'b0001;
    localparam logic [SEL_W-1:0] SHL_1 = 4'b0010;
    localparam logic [SEL_W-1:0] SHL_2 = 4'b0100;
    localparam logic [SEL_W-1:0] SHL_3 = 4'b1000;

    typedef struct packed {
        logic             neg;
        logic [SEL_W-1:0] booth_sel;
        logic [SEL_W-1:0] shift_sel;
    } booth_digit_t;

    localparam booth_digit_t DIGIT_ZERO = '{neg: 1'b0, booth_sel: SEL_NONE, shift_sel: SEL_NONE};

endpackage

// File: rtl/booth_digit_decode.sv
// Combinational decode of one 5-bit radix-16 Booth window into sign, odd-multiple
// select and shift select.
module booth_digit_decode
    import booth_encode_pkg::*;
(
    input  logic [WIN_W-1:0] win_i,
    output booth_digit_t     dig_o
);

    logic neg;

    // All-ones is the zero digit, so it must not report negative.
    assign neg = win_i[4] & ~(&win_i[3:0]);

    // NOTE: dig_o gets a full default before the case so no path can infer a latch.
    always_comb begin
        dig_o = DIGIT_ZERO;
        unique case (win_i)
            5'b00001, 5'b00010, 5'b11101, 5'b11110:
                dig_o = '{neg: neg, booth_sel: SEL_1X, shift_sel: SHL_0};
            5'b00011, 5'b00100, 5'b11011, 5'b11100:
                dig_o = '{neg: neg, booth_sel: SEL_1X, shift_sel: SHL_1};
            5'b00101, 5'b00110, 5'b11001, 5'b11010:
                dig_o = '{neg: neg, booth_sel: SEL_3X, shift_sel: SHL_0};
            5'b00111, 5'b01000, 5'b10111, 5'b11000:
                dig_o = '{neg: neg, booth_sel: SEL_1X, shift_sel: SHL_2};
            5'b01001, 5'b01010, 5'b10101, 5'b10110:
                dig_o = '{neg: neg, booth_sel: SEL_5X, shift_sel: SHL_0};
            5'b01011, 5'b01100, 5'b10011, 5'b10100:
                dig_o = '{neg: neg, booth_sel: SEL_3X, shift_sel: SHL_1};
            5'b01101, 5'b01110, 5'b10001, 5'b10010:
                dig_o = '{neg: neg, booth_sel: SEL_7X, shift_sel: SHL_0};
            5'b01111, 5'b10000:
                dig_o = '{neg: neg, booth_sel: SEL_1X, shift_sel: SHL_3};
            default:
                dig_o = DIGIT_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_encode.sv
// Radix-16 Booth digit encoder: combinational window decode followed by one
// asynchronously reset output register stage.
module booth_encode
    import booth_encode_pkg::*;
(
    input  logic             iClk,
    input  logic             iRstn,
    input  logic [WIN_W-1:0] iDat,
    output logic             oNegative,
    output logic [SEL_W-1:0] oBoothSel,
    output logic [SEL_W-1:0] oShiftSel
);

    booth_digit_t dig_d;
    booth_digit_t dig_q;

    booth_digit_decode u_decode (
        .win_i (iDat),
        .dig_o (dig_d)
    );

    // NOTE: state is updated with non-blocking assignments; reset loads the zero digit.
    always_ff @(posedge iClk or negedge iRstn) begin
        if (!iRstn) begin
            dig_q <= DIGIT_ZERO;
        end else begin
            dig_q <= dig_d;
        end
    end

    assign oNegative = dig_q.neg;
    assign oBoothSel = dig_q.booth_sel;
    assign oShiftSel = dig_q.shift_sel;

endmodule

// File: tb/tb_booth_encode.sv
// Self-checking bench for booth_encode: directed spec vectors, exhaustive sweep,
// random codes against an arithmetic reference, and reset behaviour.
module tb_booth_encode;

    logic       iClk;
    logic       iRstn;
    logic [4:0] iDat;
    logic       oNegative;
    logic [3:0] oBoothSel;
    logic [3:0] oShiftSel;
    logic [8:0] dut_out;

    int n_cmp  = 0;
    int n_fail = 0;

    booth_encode dut (
        .iClk      (iClk),
        .iRstn     (iRstn),
        .iDat      (iDat),
        .oNegative (oNegative),
        .oBoothSel (oBoothSel),
        .oShiftSel (oShiftSel)
    );

    assign dut_out = {oNegative, oBoothSel, oShiftSel};

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int digit_of(input logic [4:0] w);
        return -8 * int'(w[4]) + 4 * int'(w[3]) + 2 * int'(w[2]) + int'(w[1]) + int'(w[0]);
    endfunction

    // Reference: split |d| into odd * 2^k, then form the one-hot fields.
    function automatic logic [8:0] model(input logic [4:0] w);
        int d;
        int m;
        int k;
        logic [3:0] bsel;
        logic [3:0] ssel;
        d = digit_of(w);
        m = (d < 0) ? -d : d;
        if (m == 0) return 9'b0;
        k = 0;
        while ((m % 2) == 0) begin
            m = m / 2;
            k++;
        end
        bsel = 4'(1 << ((m - 1) / 2));
        ssel = 4'(1 << k);
        return {(d < 0), bsel, ssel};
    endfunction

    // Reconstruct the signed digit from the DUT fields.
    function automatic int value_of(input logic neg, input logic [3:0] b, input logic [3:0] s);
        int odd;
        int k;
        odd = 0;
        k = 0;
        case (b)
            4'b0001: odd = 1;
            4'b0010: odd = 3;
            4'b0100: odd = 5;
            4'b1000: odd = 7;
            default: odd = 0;
        endcase
        case (s)
            4'b0001: k = 0;
            4'b0010: k = 1;
            4'b0100: k = 2;
            4'b1000: k = 3;
            default: odd = 0;
        endcase
        return (neg ? -1 : 1) * odd * (1 << k);
    endfunction

    task automatic apply(input logic [4:0] code);
        @(negedge iClk);
        iDat = code;
        @(posedge iClk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [4:0] code, input logic [8:0] exp);
        apply(code);
        check(tag, 32'(dut_out), 32'(exp));
    endtask

    initial begin
        int d;
        int v;
        logic rule_ok;
        logic [4:0] code;

        iRstn = 1'b0;
        iDat  = 5'b10101;

        // Reset held across edges with a nonzero window.
        #2;
        check("reset_async", 32'(dut_out), 32'h0);
        repeat (3) @(posedge iClk);
        #1;
        check("reset_held", 32'(dut_out), 32'h0);

        @(negedge iClk);
        iRstn = 1'b1;
        @(posedge iClk);
        #1;
        check("reset_release_m5", 32'(dut_out), 32'(9'b1_0100_0001));

        // Zeros.
        directed("zero_00000", 5'b00000, 9'b0_0000_0000);
        directed("zero_11111", 5'b11111, 9'b0_0000_0000);

        // Positive sweep.
        directed("pos_00001", 5'b00001, 9'b0_0001_0001);
        directed("pos_00011", 5'b00011, 9'b0_0001_0010);
        directed("pos_00101", 5'b00101, 9'b0_0010_0001);
        directed("pos_01100", 5'b01100, 9'b0_0010_0010);
        directed("pos_01101", 5'b01101, 9'b0_1000_0001);
        directed("pos_01111", 5'b01111, 9'b0_0001_1000);

        // Negative sweep.
        directed("neg_10000", 5'b10000, 9'b1_0001_1000);
        directed("neg_10101", 5'b10101, 9'b1_0100_0001);
        directed("neg_11010", 5'b11010, 9'b1_0010_0001);
        directed("neg_11110", 5'b11110, 9'b1_0001_0001);

        // Exhaustive, one code per cycle.
        for (int i = 0; i < 32; i++) begin
            code = 5'(i);
            apply(code);
            d = digit_of(code);
            v = value_of(oNegative, oBoothSel, oShiftSel);
            check($sformatf("exh_model_%0d", i), 32'(dut_out), 32'(model(code)));
            check($sformatf("exh_value_%0d", i), 32'(v), 32'(d));
            rule_ok = (d == 0) ? (oBoothSel == 4'b0 && oShiftSel == 4'b0 && !oNegative)
                               : ($onehot(oBoothSel) && $onehot(oShiftSel));
            check($sformatf("exh_onehot_%0d", i), 32'(rule_ok), 32'(1'b1));
        end

        // Random codes against the reference.
        for (int i = 0; i < 200; i++) begin
            code = 5'($urandom_range(0, 31));
            apply(code);
            check($sformatf("rand_%0d_code_%0d", i, code), 32'(dut_out), 32'(model(code)));
        end

        // Mid-stream asynchronous reset.
        directed("mid_pre_01111", 5'b01111, 9'b0_0001_1000);
        #2;
        iRstn = 1'b0;
        #1;
        check("mid_async_clear", 32'(dut_out), 32'h0);
        iDat = 5'b01101;
        @(posedge iClk);
        #1;
        check("mid_inflight_discard", 32'(dut_out), 32'h0);
        @(negedge iClk);
        iRstn = 1'b1;
        iDat  = 5'b11010;
        @(posedge iClk);
        #1;
        check("mid_release_m3", 32'(dut_out), 32'(9'b1_0010_0001));
        directed("mid_track_00101", 5'b00101, 9'b0_0010_0001);
        directed("mid_track_10000", 5'b10000, 9'b1_0001_1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
